// File: rtl/colocador_bombas.sv
// colocador_bombas: clears the 8x8 minesweeper board, then places bombs (bit 6)
// at LFSR-chosen cells while keeping the first-click cell bomb-free.
module colocador_bombas #(
  parameter logic [15:0] LFSR_DEFAULT = 16'hACE1,
  parameter int          MAX_CICLOS   = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [5:0]            num_bombas,
  input  logic [15:0]           semilla,
  input  logic [2:0]            excl_fila,
  input  logic [2:0]            excl_col,
  output logic [7:0][7:0][8:0]  tablero,
  output logic                  ocupado,
  output logic                  listo,
  output logic                  error
);

  localparam int BW = $clog2(MAX_CICLOS + 1);
  localparam logic [BW-1:0] LAST_CYCLE = BW'(MAX_CICLOS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    PLACE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_r;
  state_t          state_next;
  logic [15:0]     lfsr_r;
  logic [5:0]      cnt_r;
  logic [5:0]      nb_r;
  logic [2:0]      ef_r;
  logic [2:0]      ec_r;
  logic [BW-1:0]   budget_r;

  logic            capture_s;
  logic            clear_s;
  logic            place_s;
  logic            accept_s;
  logic            err_set_s;
  logic [2:0]      row_s;
  logic [2:0]      col_s;
  logic [15:0]     lfsr_next_s;
  logic [15:0]     seed_s;

  assign row_s       = lfsr_r[5:3];
  assign col_s       = lfsr_r[2:0];
  assign lfsr_next_s = {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
  assign seed_s      = (semilla == 16'h0000) ? LFSR_DEFAULT : semilla;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state logic and per-cycle control strobes
  always_comb begin
    state_next = state_r;
    capture_s  = 1'b0;
    clear_s    = 1'b0;
    place_s    = 1'b0;
    accept_s   = 1'b0;
    err_set_s  = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          capture_s  = 1'b1;
          state_next = CLEAR;
        end else begin
          state_next = state_r;
        end
      end
      CLEAR: begin
        clear_s = 1'b1;
        if (nb_r == 6'd0) begin
          state_next = DONE;
        end else begin
          state_next = PLACE;
        end
      end
      PLACE: begin
        place_s  = 1'b1;
        accept_s = !tablero[row_s][col_s][6] && !((row_s == ef_r) && (col_s == ec_r));
        if ((cnt_r + {5'b00000, accept_s}) == nb_r) begin
          state_next = DONE;
        end else if (budget_r == LAST_CYCLE) begin
          state_next = DONE;
          err_set_s  = 1'b1;
        end else begin
          state_next = PLACE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request capture, board clearing and bomb placement
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tablero  <= '0;
      lfsr_r   <= LFSR_DEFAULT;
      cnt_r    <= 6'd0;
      nb_r     <= 6'd0;
      ef_r     <= 3'd0;
      ec_r     <= 3'd0;
      budget_r <= '0;
    end else if (capture_s) begin
      nb_r   <= num_bombas;
      ef_r   <= excl_fila;
      ec_r   <= excl_col;
      lfsr_r <= seed_s;
    end else if (clear_s) begin
      tablero  <= '0;
      cnt_r    <= 6'd0;
      budget_r <= '0;
    end else if (place_s) begin
      lfsr_r   <= lfsr_next_s;
      budget_r <= budget_r + BW'(1);
      if (accept_s) begin
        tablero[row_s][col_s] <= 9'h040;
        cnt_r                 <= cnt_r + 6'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  // Status flags registered from the next state so they line up with it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ocupado <= 1'b0;
      listo   <= 1'b0;
      error   <= 1'b0;
    end else begin
      ocupado <= (state_next == CLEAR) || (state_next == PLACE);
      listo   <= (state_next == DONE);
      if (capture_s) begin
        error <= 1'b0;
      end else if (err_set_s) begin
        error <= 1'b1;
      end else begin
        error <= error;
      end
    end
  end

endmodule

// File: tb/tb_colocador_bombas.sv
// Directed bench for colocador_bombas: table of requests checked against an
// independent placement model, plus busy-start, mid-run reset and budget cases.
module tb_colocador_bombas;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic                 start, start2;
  logic [5:0]           num_bombas, num2;
  logic [15:0]          semilla;
  logic [2:0]           excl_fila, excl_col;
  logic [7:0][7:0][8:0] tablero, tablero2;
  logic                 ocupado, listo, error;
  logic                 ocupado2, listo2, error2;

  int tests = 0;
  int fails = 0;

  colocador_bombas dut (
    .clk(clk), .reset(reset), .start(start), .num_bombas(num_bombas),
    .semilla(semilla), .excl_fila(excl_fila), .excl_col(excl_col),
    .tablero(tablero), .ocupado(ocupado), .listo(listo), .error(error)
  );

  colocador_bombas #(.MAX_CICLOS(8)) dut_small (
    .clk(clk), .reset(reset), .start(start2), .num_bombas(num2),
    .semilla(semilla), .excl_fila(excl_fila), .excl_col(excl_col),
    .tablero(tablero2), .ocupado(ocupado2), .listo(listo2), .error(error2)
  );

  typedef struct {
    logic [5:0]  n;
    logic [15:0] seed;
    logic [2:0]  ef;
    logic [2:0]  ec;
    int          exp_pop;
    int          exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_board(input string name, input logic [7:0][7:0][8:0] act,
                             input logic [7:0][7:0][8:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int popcount(input logic [7:0][7:0][8:0] b);
    int c = 0;
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++)
        if (b[r][k][6]) c++;
    return c;
  endfunction

  function automatic int bad_cells(input logic [7:0][7:0][8:0] b);
    int c = 0;
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++)
        if (b[r][k] !== 9'h000 && b[r][k] !== 9'h040) c++;
    return c;
  endfunction

  // Reference placement: one candidate per cycle from the low LFSR bits
  task automatic model(input logic [5:0] n, input logic [15:0] seed, input logic [2:0] ef,
                       input logic [2:0] ec, input int maxc,
                       output logic [7:0][7:0][8:0] b, output int p, output int err);
    logic [15:0] l;
    logic [2:0]  r, k;
    int          cnt;
    l   = (seed == 16'h0000) ? 16'hACE1 : seed;
    b   = '0;
    p   = 0;
    err = 0;
    cnt = 0;
    while (n != 6'd0) begin
      r = l[5:3];
      k = l[2:0];
      if (b[r][k][6] == 1'b0 && !(r == ef && k == ec)) begin
        b[r][k] = 9'h040;
        cnt++;
      end
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      p++;
      if (cnt == int'(n)) break;
      if (p == maxc) begin
        err = 1;
        break;
      end
    end
  endtask

  task automatic run_start(input logic [5:0] n, input logic [15:0] s, input logic [2:0] ef,
                           input logic [2:0] ec, output int cyc, output int ocu0, output int lis0);
    @(negedge clk);
    num_bombas = n; semilla = s; excl_fila = ef; excl_col = ec; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ocu0 = int'(ocupado);
    lis0 = int'(listo);
    cyc  = 0;
    while (!listo && cyc < 6000) begin
      @(negedge clk);
      cyc++;
    end
    check("wait_listo_timeout", int'(cyc < 6000), 1);
  endtask

  logic [7:0][7:0][8:0] mb;
  int mp, merr, cyc, ocu0, lis0, guard;

  initial begin
    vecs[0] = '{n: 6'd0,  seed: 16'h1234, ef: 3'd2, ec: 3'd2, exp_pop: 0,  exp_err: 0};
    vecs[1] = '{n: 6'd10, seed: 16'h0001, ef: 3'd3, ec: 3'd4, exp_pop: 10, exp_err: 0};
    vecs[2] = '{n: 6'd63, seed: 16'h0000, ef: 3'd0, ec: 3'd0, exp_pop: 63, exp_err: 0};
    vecs[3] = '{n: 6'd63, seed: 16'hACE1, ef: 3'd0, ec: 3'd0, exp_pop: 63, exp_err: 0};
    vecs[4] = '{n: 6'd1,  seed: 16'hBEEF, ef: 3'd7, ec: 3'd7, exp_pop: 1,  exp_err: 0};
    vecs[5] = '{n: 6'd5,  seed: 16'hFFFF, ef: 3'd5, ec: 3'd1, exp_pop: 5,  exp_err: 0};

    reset = 1'b0; start = 1'b0; start2 = 1'b0; num_bombas = 6'd0; num2 = 6'd0;
    semilla = 16'h0000; excl_fila = 3'd0; excl_col = 3'd0;
    repeat (2) @(negedge clk);
    check_board("reset_board", tablero, '0);
    check("reset_ocupado", int'(ocupado), 0);
    check("reset_listo", int'(listo), 0);
    check("reset_error", int'(error), 0);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      model(vecs[i].n, vecs[i].seed, vecs[i].ef, vecs[i].ec, 4096, mb, mp, merr);
      run_start(vecs[i].n, vecs[i].seed, vecs[i].ef, vecs[i].ec, cyc, ocu0, lis0);
      check($sformatf("v%0d_ocupado_after_start", i), ocu0, 1);
      check($sformatf("v%0d_listo_drops", i), lis0, 0);
      check($sformatf("v%0d_latency", i), cyc, 1 + mp);
      check($sformatf("v%0d_popcount", i), popcount(tablero), vecs[i].exp_pop);
      check($sformatf("v%0d_error", i), int'(error), vecs[i].exp_err);
      check($sformatf("v%0d_excl_cell", i), int'(tablero[vecs[i].ef][vecs[i].ec]), 0);
      check($sformatf("v%0d_cell_values", i), bad_cells(tablero), 0);
      check_board($sformatf("v%0d_board", i), tablero, mb);
    end
    repeat (5) @(negedge clk);
    check_board("done_hold_board", tablero, mb);
    check("done_hold_listo", int'(listo), 1);

    // Second start while busy, with different inputs, must be ignored
    model(6'd10, 16'h0001, 3'd3, 3'd4, 4096, mb, mp, merr);
    @(negedge clk);
    num_bombas = 6'd10; semilla = 16'h0001; excl_fila = 3'd3; excl_col = 3'd4; start = 1'b1;
    @(negedge clk);
    num_bombas = 6'd3; semilla = 16'h7777; excl_fila = 3'd0; excl_col = 3'd0;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!listo && guard < 6000) begin
      @(negedge clk);
      guard++;
    end
    check("busy_start_timeout", int'(guard < 6000), 1);
    check("busy_start_popcount", popcount(tablero), 10);
    check_board("busy_start_board", tablero, mb);

    // Reset asserted mid-placement once five bombs are down
    @(negedge clk);
    num_bombas = 6'd20; semilla = 16'h2468; excl_fila = 3'd1; excl_col = 3'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (popcount(tablero) != 5 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("midreset_reach5", popcount(tablero), 5);
    reset = 1'b0;
    #1;
    check_board("midreset_board", tablero, '0);
    check("midreset_ocupado", int'(ocupado), 0);
    check("midreset_listo", int'(listo), 0);
    check("midreset_error", int'(error), 0);
    @(negedge clk);
    reset = 1'b1;
    model(6'd7, 16'h0BAD, 3'd6, 3'd2, 4096, mb, mp, merr);
    run_start(6'd7, 16'h0BAD, 3'd6, 3'd2, cyc, ocu0, lis0);
    check("rebuild_latency", cyc, 1 + mp);
    check_board("rebuild_board", tablero, mb);

    // Budget exhaustion on the 8-cycle instance
    model(6'd63, 16'h0001, 3'd0, 3'd0, 8, mb, mp, merr);
    @(negedge clk);
    num2 = 6'd63; semilla = 16'h0001; excl_fila = 3'd0; excl_col = 3'd0; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 0;
    while (!listo2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("budget_latency", cyc, 9);
    check("budget_error", int'(error2), 1);
    check("budget_popcount_le8", int'(popcount(tablero2) <= 8), 1);
    check_board("budget_board", tablero2, mb);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
